imul_rr_sharer: RTL
===================

// Module: imul_rr_sharer
// PURPOSE
//  Shares one val/rdy integer multiplier (64b req {a,b}, 32b resp) among NREQ requesters.
//  - Round-robin arbitration; one transaction in flight at a time.
//  - Response is registered and returned to the requester that issued it.
//  - Sits between requester streams and the multiplier (fixed or variable latency).
// PARAMETERS
//  NREQ      2    number of requesters, 1..8
//  NREQ_LG   1    $clog2(NREQ), minimum 1; width of grant index/pointer
// PORTS
//  clk          in   1          clock; all state updates on posedge
//  reset        in   1          synchronous reset, active-low (0 = reset)
//  istream_val  in   NREQ       per-requester request valid
//  istream_rdy  out  NREQ       per-requester request ready; at most one bit set (one-hot)
//  istream_msg  in   NREQ*64    requester i at [64i+63:64i] = {a[31:0], b[31:0]}
//  ostream_val  out  NREQ       per-requester response valid; at most one bit set (one-hot)
//  ostream_rdy  in   NREQ       per-requester response ready
//  ostream_msg  out  NREQ*32    product; every 32b slice carries the same result register
//  mul_req_val  out  1          to multiplier
//  mul_req_rdy  in   1
//  mul_req_msg  out  64         latched {a,b}
//  mul_resp_val in   1          from multiplier
//  mul_resp_rdy out  1
//  mul_resp_msg in   32
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - state=IDLE; rr pointer=0; operand, owner and result registers=0.
//  - All val/rdy outputs are 0 on the cycle after reset; msg outputs are 0.
//  - Reset mid-transaction abandons it silently.
//  - The multiplier must be reset in the same cycle, so that no stale response survives.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE
//  - Grant g = first i with istream_val[i]=1, scanning from ptr upward mod NREQ.
//  - Drive istream_rdy[g]=1 combinationally; all other rdy bits are 0.
//  - If any valid: latch msg[g] into the operand register, set owner=g, go to ISSUE.
//  - No valid requester: stay in IDLE; all rdy bits are 0.
//  ISSUE
//  - mul_req_val=1, mul_req_msg=operand register.
//  - mul_req_rdy=1 -> WAIT; otherwise hold ISSUE with msg stable.
//  WAIT
//  - mul_resp_rdy=1.
//  - mul_resp_val=1 -> latch mul_resp_msg into the result register, go to RESP.
//  RESP
//  - ostream_val[owner]=1, ostream_msg=result register.
//  - ostream_rdy[owner]=1 -> ptr=(owner+1) mod NREQ, go to IDLE.
//  - ostream_rdy of non-owners is ignored.
//  Outside its own state, each handshake output is 0:
//  - mul_resp_rdy=0 outside WAIT, so a stray mul_resp_val is ignored.
//  - istream_rdy=0 outside IDLE, so no new request is accepted while busy.
//  Latency, requester accept to ostream_val: 3 cycles + multiplier latency (all rdys high).
//  - Minimum occupancy: 4 cycles per transaction; a new accept is possible in the cycle after RESP.
//  Pointer: updated only on the RESP handshake; wraps from NREQ-1 to 0.
//  - A requester that just completed has the lowest priority in the next IDLE, so no starvation.
//  - NREQ=1: pointer stays 0; the block is a registered single-slot sequencer.
//  Arithmetic: products are truncated to 32b by the multiplier; the sharer does not modify data.
// CONFIGURATION
//  IMUL_SHARER_ZERO_BYPASS_EN
//  - Defined: in IDLE, if latched a==0 or b==0, go directly to RESP with result=0.
//    The multiplier is never requested; latency is 1 cycle.
//  - Undefined: every request goes through ISSUE/WAIT. No bypass logic is synthesized.
// TESTING
//  1. NREQ=2, req0 {3,5}, multiplier latency 4, ostream_rdy=1
//     -> ostream_val[0] 7 cycles after accept, msg=15, ptr=1.
//  2. Both val in the same cycle, req0 {2,3}, req1 {4,5}, ptr=0
//     -> req0 served first (6); req1 served next (20); ptr ends at 0.
//  3. mul_req_rdy low for 3 cycles in ISSUE -> mul_req_msg stable, no duplicate issue.
//     ostream_rdy[1]=0 for 5 cycles in RESP -> ostream_val[1] and msg held, istream_rdy=0.
//  4. reset=0 asserted during WAIT
//     -> next cycle all val/rdy=0, state IDLE, ptr=0; the following request completes correctly.
//  5. {0xFFFFFFFF,2} -> 0xFFFFFFFE.
//     Stray mul_resp_val pulse in IDLE -> ignored, mul_resp_rdy=0.
//  6. With IMUL_SHARER_ZERO_BYPASS_EN: {0,7} -> mul_req_val never set, ostream_val 1 cycle after accept, msg=0.
//     Without it: normal path.

Source files
------------

// File: rtl/imul_rr_sharer_if.sv
// imul_rr_sharer_if: requester, response and multiplier handshakes
// for the shared integer multiplier front end.
interface imul_rr_sharer_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    istream_val;
  logic [NREQ-1:0]    istream_rdy;
  logic [NREQ*64-1:0] istream_msg;
  logic [NREQ-1:0]    ostream_val;
  logic [NREQ-1:0]    ostream_rdy;
  logic [NREQ*32-1:0] ostream_msg;
  logic               mul_req_val;
  logic               mul_req_rdy;
  logic [63:0]        mul_req_msg;
  logic               mul_resp_val;
  logic               mul_resp_rdy;
  logic [31:0]        mul_resp_msg;

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    output mul_req_rdy, mul_resp_val, mul_resp_msg,
    input  istream_rdy, ostream_val, ostream_msg,
    input  mul_req_val, mul_req_msg, mul_resp_rdy
  );

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    input  mul_req_rdy, mul_resp_val, mul_resp_msg,
    output istream_rdy, ostream_val, ostream_msg,
    output mul_req_val, mul_req_msg, mul_resp_rdy
  );
endinterface

// File: rtl/imul_rr_sharer.sv
// imul_rr_sharer: round-robin sharing of one val/rdy multiplier.
// Optional IMUL_SHARER_ZERO_BYPASS_EN: zero operand skips the multiplier.
module imul_rr_sharer #(
  parameter int NREQ    = 2,
  parameter int NREQ_LG = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic             clk,
  input logic             reset,
  imul_rr_sharer_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]         state;
  logic [NREQ_LG-1:0] ptr;
  logic [NREQ_LG-1:0] owner;
  logic [63:0]        opnd;
  logic [31:0]        result;

  logic               gnt_any;
  logic [NREQ_LG-1:0] gnt_idx;
  logic [63:0]        gnt_msg;
  logic [NREQ_LG-1:0] nxt_ptr;
  int                 idx;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_any && bus.istream_val[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = NREQ_LG'(idx);
      end
    end
  end

  assign gnt_msg = bus.istream_msg[int'(gnt_idx)*64 +: 64];
  assign nxt_ptr = (owner == NREQ_LG'(NREQ - 1))
                 ? '0 : owner + 1'b1;

  assign bus.istream_rdy  = (state == IDLE && gnt_any)
                          ? NREQ'(1) << gnt_idx : '0;
  assign bus.ostream_val  = (state == RESP)
                          ? NREQ'(1) << owner : '0;
  assign bus.ostream_msg  = {NREQ{result}};
  assign bus.mul_req_val  = (state == ISSUE);
  assign bus.mul_req_msg  = opnd;
  assign bus.mul_resp_rdy = (state == WAIT);

  // transaction sequencer: accept, issue, wait, respond
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      opnd   <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            opnd  <= gnt_msg;
            owner <= gnt_idx;
`ifdef IMUL_SHARER_ZERO_BYPASS_EN
            if (gnt_msg[63:32] == 32'd0 ||
                gnt_msg[31:0] == 32'd0) begin
              result <= '0;
              state  <= RESP;
            end else begin
              state  <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          if (bus.mul_req_rdy) state <= WAIT;
        end
        WAIT: begin
          if (bus.mul_resp_val) begin
            result <= bus.mul_resp_msg;
            state  <= RESP;
          end
        end
        RESP: begin
          if (bus.ostream_rdy[owner]) begin
            ptr   <= nxt_ptr;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
